// File: rtl/fft_pkg.sv
// Shared types for the R2SDF FFT stages: sample width, complex pair, stage FSM states,
// and the trivial -j twiddle rotation.
package fft_pkg;

  localparam int DATA_W = 24;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [2:0] {IDLE, FILL, RUN, PAD, FLUSH} state_t;

  // Multiply by -j: (re, im) -> (im, -re); negating the most negative value wraps.
  function automatic cplx_t rot_mj(input cplx_t x);
    cplx_t y;
    y.re = x.im;
    y.im = -x.re;
    return y;
  endfunction

endpackage

// File: rtl/bf2_core.sv
// Radix-2 butterfly: s = a + b, d = a - b formed at DATA_W+1 bits, then halved (SCALE=1)
// or wrapped back to DATA_W (SCALE=0). Purely combinational.
module bf2_core #(
  parameter int DATA_W = 24,
  parameter bit SCALE  = 1'b0
) (
  input  logic [DATA_W-1:0] a_re_i,
  input  logic [DATA_W-1:0] a_im_i,
  input  logic [DATA_W-1:0] b_re_i,
  input  logic [DATA_W-1:0] b_im_i,
  output logic [DATA_W-1:0] s_re_o,
  output logic [DATA_W-1:0] s_im_o,
  output logic [DATA_W-1:0] d_re_o,
  output logic [DATA_W-1:0] d_im_o
);

  generate
    if (SCALE) begin : g_half
      logic [DATA_W:0] s_re_w, s_im_w, d_re_w, d_im_w;
      logic            unused_lsb;

      assign s_re_w = {a_re_i[DATA_W-1], a_re_i} + {b_re_i[DATA_W-1], b_re_i};
      assign s_im_w = {a_im_i[DATA_W-1], a_im_i} + {b_im_i[DATA_W-1], b_im_i};
      assign d_re_w = {a_re_i[DATA_W-1], a_re_i} - {b_re_i[DATA_W-1], b_re_i};
      assign d_im_w = {a_im_i[DATA_W-1], a_im_i} - {b_im_i[DATA_W-1], b_im_i};

      // Dropping the LSB of the extended result is the arithmetic shift right by one.
      assign s_re_o = s_re_w[DATA_W:1];
      assign s_im_o = s_im_w[DATA_W:1];
      assign d_re_o = d_re_w[DATA_W:1];
      assign d_im_o = d_im_w[DATA_W:1];
      assign unused_lsb = ^{s_re_w[0], s_im_w[0], d_re_w[0], d_im_w[0]};
    end else begin : g_wrap
      assign s_re_o = a_re_i + b_re_i;
      assign s_im_o = a_im_i + b_im_i;
      assign d_re_o = a_re_i - b_re_i;
      assign d_im_o = a_im_i - b_im_i;
    end
  endgenerate

endmodule

// File: rtl/fft_bf2_stage5.sv
// Stage-5 R2SDF butterfly of the 64-point DIF FFT with W4 twiddles (1, -j), driving an
// external DELAY-deep feedback line; one cycle from accepted sample to registered dout.
module fft_bf2_stage5
  import fft_pkg::*;
#(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int DELAY  = 2,
  parameter bit SCALE  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din_r,
  input  logic [DATA_W-1:0] din_i,
  input  logic [DATA_W-1:0] fb_r,
  input  logic [DATA_W-1:0] fb_i,
  output logic [DATA_W-1:0] to_fb_r,
  output logic [DATA_W-1:0] to_fb_i,
  output logic              shift_en,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout_r,
  output logic [DATA_W-1:0] dout_i
);

  localparam int               CNT_W     = $clog2(2 * DELAY);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'(2 * DELAY - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fl_data_q;
  logic             out_valid_q;
  cplx_t            dout_q, dout_d;
  cplx_t            din_w, fb_w, sum_w, diff_w, to_fb_w;
  logic             active, phase, tw;

  assign active = in_valid || (state_q == FLUSH) || (state_q == PAD);
  assign phase  = cnt_q[CNT_W-1];
  assign tw     = cnt_q[0];

  // Non-data slots in PAD/FLUSH feed zeros so the block completes and drains cleanly.
  assign din_w.re = in_valid ? din_r : '0;
  assign din_w.im = in_valid ? din_i : '0;
  assign fb_w.re  = fb_r;
  assign fb_w.im  = fb_i;

  bf2_core #(.DATA_W(DATA_W), .SCALE(SCALE)) u_bf2 (
    .a_re_i (fb_w.re),
    .a_im_i (fb_w.im),
    .b_re_i (din_w.re),
    .b_im_i (din_w.im),
    .s_re_o (sum_w.re),
    .s_im_o (sum_w.im),
    .d_re_o (diff_w.re),
    .d_im_o (diff_w.im)
  );

  assign to_fb_w = phase ? diff_w : din_w;
  assign dout_d  = phase ? sum_w : (tw ? rot_mj(fb_w) : fb_w);

  assign to_fb_r   = to_fb_w.re;
  assign to_fb_i   = to_fb_w.im;
  assign shift_en  = active;
  assign out_valid = out_valid_q;
  assign dout_r    = dout_q.re;
  assign dout_i    = dout_q.im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fl_data_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      // FILL slots carry no stored data yet, so only later states produce output.
      out_valid_q <= active && (state_q != IDLE) && (state_q != FILL);
      if (active) begin
        cnt_q  <= cnt_q + 1'b1;
        dout_q <= dout_d;
      end
      case (state_q)
        IDLE:  if (in_valid) state_q <= FILL;
        FILL:  if (in_valid && cnt_q == HALF_LAST) state_q <= RUN;
        RUN:   if (!in_valid) state_q <= (cnt_q == '0) ? FLUSH : PAD;
        PAD: begin
          if (in_valid)              state_q <= RUN;
          else if (cnt_q == BLK_LAST) state_q <= FLUSH;
        end
        FLUSH: begin
          if (in_valid) fl_data_q <= 1'b1;
          if (cnt_q == HALF_LAST) begin
            fl_data_q <= 1'b0;
            if (in_valid || fl_data_q) begin
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bf2_stage5.sv
// Directed and randomized checks of fft_bf2_stage5 (SCALE=0 and SCALE=1 side by side)
// against a block-level DIF radix-2 model; the 2-deep feedback line is modelled here.
module tb_fft_bf2_stage5;
  import fft_pkg::*;

  localparam int W = 24;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] din_r    = '0;
  logic [W-1:0] din_i    = '0;

  logic [W-1:0] fb_r0, fb_i0, to_fb_r0, to_fb_i0, dout_r0, dout_i0;
  logic [W-1:0] fb_r1, fb_i1, to_fb_r1, to_fb_i1, dout_r1, dout_i1;
  logic         shift_en0, out_valid0, shift_en1, out_valid1;

  logic [2*W-1:0] dl0_a = '0, dl0_b = '0, dl1_a = '0, dl1_b = '0;

  int vectors     = 0;
  int miscompares = 0;
  int run_len     = 0;
  int max_run     = 0;

  logic [2*W-1:0] q0[$];
  logic [2*W-1:0] q1[$];
  logic [2*W-1:0] frm[$];

  fft_bf2_stage5 #(.DATA_W(W), .DELAY(2), .SCALE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .fb_r(fb_r0), .fb_i(fb_i0), .to_fb_r(to_fb_r0), .to_fb_i(to_fb_i0),
    .shift_en(shift_en0), .out_valid(out_valid0), .dout_r(dout_r0), .dout_i(dout_i0)
  );

  fft_bf2_stage5 #(.DATA_W(W), .DELAY(2), .SCALE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .fb_r(fb_r1), .fb_i(fb_i1), .to_fb_r(to_fb_r1), .to_fb_i(to_fb_i1),
    .shift_en(shift_en1), .out_valid(out_valid1), .dout_r(dout_r1), .dout_i(dout_i1)
  );

  always #5 clk = ~clk;

  // shift_2 delay line: fb is the value pushed two advances earlier; never reset.
  always @(posedge clk) begin
    if (shift_en0) begin
      dl0_b <= dl0_a;
      dl0_a <= {to_fb_r0, to_fb_i0};
    end
    if (shift_en1) begin
      dl1_b <= dl1_a;
      dl1_a <= {to_fb_r1, to_fb_i1};
    end
  end
  assign fb_r0 = dl0_b[2*W-1:W];
  assign fb_i0 = dl0_b[W-1:0];
  assign fb_r1 = dl1_b[2*W-1:W];
  assign fb_i1 = dl1_b[W-1:0];

  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [W-1:0] sc(input longint v, input bit half);
    longint t;
    t = half ? (v >>> 1) : v;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd24();
    logic [31:0] u;
    u = $urandom();
    case (u[31:29])
      3'd0:    return 24'h7FFFFF;
      3'd1:    return 24'h800000;
      default: return u[W-1:0];
    endcase
  endfunction

  // Per 4-sample block (zero-padded): x0+x2, x1+x3, x0-x2, -j*(x1-x3).
  task automatic model_frame();
    logic [2*W-1:0] x[$];
    logic [2*W-1:0] o[4];
    longint         ar[4], ai[4];
    logic [W-1:0]   t;
    bit             half;
    x = frm;
    while (x.size() % 4 != 0) x.push_back('0);
    for (int b = 0; b < x.size(); b += 4) begin
      for (int k = 0; k < 4; k++) begin
        ar[k] = sx(x[b+k][2*W-1:W]);
        ai[k] = sx(x[b+k][W-1:0]);
      end
      for (int s = 0; s < 2; s++) begin
        half = (s == 1);
        o[0] = {sc(ar[0] + ar[2], half), sc(ai[0] + ai[2], half)};
        o[1] = {sc(ar[1] + ar[3], half), sc(ai[1] + ai[3], half)};
        o[2] = {sc(ar[0] - ar[2], half), sc(ai[0] - ai[2], half)};
        t    = sc(ar[1] - ar[3], half);
        o[3] = {sc(ai[1] - ai[3], half), -t};
        for (int k = 0; k < 4; k++) begin
          if (s == 0) q0.push_back(o[k]);
          else        q1.push_back(o[k]);
        end
      end
    end
  endtask

  // One clock: mid-cycle input-side check, then outputs checked 1 time unit after the edge.
  task automatic step();
    #3;
    if (in_valid) chk("shift_en", 48'({shift_en0, shift_en1}), 48'(2'b11));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      run_len = 0;
    end else begin
      if (out_valid0) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (q0.size() > 0) chk("dout0", {dout_r0, dout_i0}, q0.pop_front());
        else               chk("dout0_extra", {dout_r0, dout_i0}, 'x);
      end else begin
        run_len = 0;
      end
      if (out_valid1) begin
        if (q1.size() > 0) chk("dout1", {dout_r1, dout_i1}, q1.pop_front());
        else               chk("dout1_extra", {dout_r1, dout_i1}, 'x);
      end
    end
  endtask

  task automatic send(input int n_drive, input bit chk_ov);
    model_frame();
    for (int i = 0; i < n_drive; i++) begin
      in_valid = 1'b1;
      din_r    = frm[i][2*W-1:W];
      din_i    = frm[i][W-1:0];
      step();
      if (chk_ov) chk("ov_timing", 48'(out_valid0), 48'(i >= 2));
    end
    in_valid = 1'b0;
    din_r    = '0;
    din_i    = '0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 40) begin
      step();
      t++;
    end
    chk({tag, "_left0"}, 48'(q0.size()), '0);
    chk({tag, "_left1"}, 48'(q1.size()), '0);
    q0.delete();
    q1.delete();
    repeat (3) step();
    chk({tag, "_idle"}, 48'({dut0.state_q, dut1.state_q}), 48'({IDLE, IDLE}));
    #3;
    chk({tag, "_se_idle"}, 48'({shift_en0, shift_en1}), '0);
  endtask

  task automatic fill_rand(input int n);
    frm.delete();
    for (int k = 0; k < n; k++) frm.push_back({rnd24(), rnd24()});
  endtask

  initial begin
    #2;
    chk("rst_ov", 48'({out_valid0, out_valid1}), '0);
    chk("rst_dout0", {dout_r0, dout_i0}, '0);
    chk("rst_dout1", {dout_r1, dout_i1}, '0);
    chk("rst_se", 48'({shift_en0, shift_en1}), '0);
    chk("rst_state", 48'({dut0.state_q, dut1.state_q}), 48'({IDLE, IDLE}));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    frm.delete();
    for (int k = 1; k <= 4; k++) frm.push_back({24'(k), 24'd0});
    send(4, 1'b1);
    drain("basic");

    frm.delete();
    frm.push_back({24'h7FFFFF, 24'd0});
    frm.push_back('0);
    frm.push_back({24'h7FFFFF, 24'd0});
    frm.push_back('0);
    send(4, 1'b0);
    drain("ovf");

    frm.delete();
    for (int k = 1; k <= 3; k++) frm.push_back({24'(k), 24'd0});
    send(3, 1'b0);
    drain("pad");

    for (int f = 0; f < 8; f++) begin
      fill_rand(int'($urandom_range(2, 20)));
      send(frm.size(), 1'b0);
      drain("rand");
    end

    // New frame arriving in the first FLUSH slot.
    fill_rand(8);
    send(8, 1'b0);
    step();
    fill_rand(8);
    send(8, 1'b0);
    drain("ovl");

    fill_rand(128);
    send(128, 1'b0);
    drain("b2b");
    chk("b2b_run", 48'(max_run), 48'(126));

    fill_rand(12);
    send(8, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 48'({out_valid0, out_valid1}), '0);
    chk("mid_rst_dout0", {dout_r0, dout_i0}, '0);
    chk("mid_rst_dout1", {dout_r1, dout_i1}, '0);
    q0.delete();
    q1.delete();
    step();
    step();
    rst_n = 1'b1;
    fill_rand(10);
    send(10, 1'b0);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
